// File: rtl/seg_scan_if.sv
// seg_scan_if - signal bundle between the time-keeping core / display pins
// and the seg_scan_mux display driver.
//   digits_in : packed 4-bit digit values, [3:0] = digit 0
//   left/right: one-cycle cursor move pulses
//   blink_en  : request blinking of the cursor digit (SEG_BLINK_EN builds)
//   cursor    : one-hot cursor, MSB = digit 0
//   seg_com   : one-hot common select, MSB = digit 0
//   seg_data  : {a,b,c,d,e,f,g,dp}, active-high
// master = digit source / stimulus side, slave = seg_scan_mux.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 6
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    left;
  logic                    right;
  logic                    blink_en;
  logic [NUM_DIGITS-1:0]   cursor;
  logic [NUM_DIGITS-1:0]   seg_com;
  logic [7:0]              seg_data;

  modport master (
    output digits_in, left, right, blink_en,
    input  cursor, seg_com, seg_data
  );

  modport slave (
    input  digits_in, left, right, blink_en,
    output cursor, seg_com, seg_data
  );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux - N-digit multiplexed 7-segment driver with an edit cursor.
// Scans digits_in onto one shared segment bus, one digit per SCAN_DIV clocks,
// with a one-hot common select. A one-hot cursor moved by left/right pulses
// is shown on the decimal point of the digit it points at.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : seg_scan_if.slave (digits_in, left, right, blink_en in;
//          cursor, seg_com, seg_data out)
// Optional feature macro: SEG_BLINK_EN
//   defined     -> cursor digit segments blink with half-period BLINK_DIV
//   not defined -> blink_en ignored, BLINK_DIV unused
module seg_scan_mux #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 10000,
  parameter int BLINK_DIV  = 1500000
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] FIRST_SEL = {1'b1, {(NUM_DIGITS-1){1'b0}}};

  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         scan_idx;
  logic [IW-1:0]         next_idx;
  logic                  tick;
  logic [NUM_DIGITS-1:0] seg_com_q;
  logic [NUM_DIGITS-1:0] cursor_q;
  logic [7:0]            seg_data_q;
  logic [3:0]            cur_digit;
  logic [6:0]            seg7;
  logic                  cur_hit;
  logic                  mv_left;
  logic                  mv_right;
  logic                  blank;

  assign tick     = (scan_cnt == SW'(SCAN_DIV - 1));
  assign mv_right = bus.right & ~bus.left;
  assign mv_left  = bus.left & ~bus.right;

  // seg_data is loaded with the digit that will be selected after this edge,
  // so segments and common select switch together.
  always_comb begin
    next_idx = scan_idx;
    if (tick) begin
      next_idx = (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  assign cur_digit = bus.digits_in[next_idx*4 +: 4];
  assign cur_hit   = cursor_q[IW'(NUM_DIGITS - 1) - next_idx];

  always_comb begin
    case (cur_digit)
      4'h0:    seg7 = 7'b1111110;
      4'h1:    seg7 = 7'b0110000;
      4'h2:    seg7 = 7'b1101101;
      4'h3:    seg7 = 7'b1111001;
      4'h4:    seg7 = 7'b0110011;
      4'h5:    seg7 = 7'b1011011;
      4'h6:    seg7 = 7'b1011111;
      4'h7:    seg7 = 7'b1110000;
      4'h8:    seg7 = 7'b1111111;
      4'h9:    seg7 = 7'b1111011;
      4'hA:    seg7 = 7'b1110111;
      4'hB:    seg7 = 7'b0011111;
      4'hC:    seg7 = 7'b1001110;
      4'hD:    seg7 = 7'b0111101;
      4'hE:    seg7 = 7'b1001111;
      4'hF:    seg7 = 7'b1000111;
      default: seg7 = 7'b0000000;
    endcase
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  // A cursor move restarts the blink so the new digit shows immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (mv_left || mv_right) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank = bus.blink_en & blink_ph & cur_hit;
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_blink_en;

  assign unused_blink_en = bus.blink_en;
  assign blank           = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt   <= '0;
      scan_idx   <= '0;
      seg_com_q  <= FIRST_SEL;
      cursor_q   <= FIRST_SEL;
      seg_data_q <= 8'h00;
    end else begin
      scan_cnt   <= tick ? '0 : scan_cnt + 1'b1;
      scan_idx   <= next_idx;
      if (tick) begin
        seg_com_q <= {seg_com_q[0], seg_com_q[NUM_DIGITS-1:1]};
      end
      if (mv_right) begin
        cursor_q <= {cursor_q[NUM_DIGITS-2:0], cursor_q[NUM_DIGITS-1]};
      end else if (mv_left) begin
        cursor_q <= {cursor_q[0], cursor_q[NUM_DIGITS-1:1]};
      end
      seg_data_q <= {(blank ? 7'b0000000 : seg7), cur_hit};
    end
  end

  assign bus.seg_com  = seg_com_q;
  assign bus.cursor   = cursor_q;
  assign bus.seg_data = seg_data_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux - self-checking bench for seg_scan_mux.
// The reference model tracks edges since reset release, the cursor position
// as an integer and (with SEG_BLINK_EN) the blink timing, and derives the
// expected outputs from those with plain arithmetic.
module tb_seg_scan_mux;
  localparam int N = 6;
  localparam int S = 4;
  localparam int B = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(N)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS(N),
    .SCAN_DIV  (S),
    .BLINK_DIV (B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // model state
  int         k;     // edges since reset release
  int         pos;   // cursor digit number
  int         bcnt;
  bit         bph;
  logic [7:0] exp_data;

  logic [6:0] seg_tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k        = 0;
    pos      = 0;
    bcnt     = 0;
    bph      = 1'b0;
    exp_data = 8'h00;
  endtask

  task automatic check_outs(input string tag);
    int idx;
    idx = (k / S) % N;
    chk({tag, " seg_com"},  32'(bus.seg_com),  32'(1 << (N - 1 - idx)));
    chk({tag, " cursor"},   32'(bus.cursor),   32'(1 << (N - 1 - pos)));
    chk({tag, " seg_data"}, 32'(bus.seg_data), 32'(exp_data));
  endtask

  // one clock: drive inputs, take the edge, advance the model, compare
  task automatic step(input string tag, input bit l, input bit r,
                      input logic [23:0] d, input bit be);
    int idx;
    bit hit;
    @(negedge clk);
    bus.left      = l;
    bus.right     = r;
    bus.digits_in = d;
    bus.blink_en  = be;
    @(posedge clk);
    k++;
    idx      = (k / S) % N;
    hit      = (idx == pos);
    exp_data = {seg_tbl[d[idx*4 +: 4]], hit};
`ifdef SEG_BLINK_EN
    if (be && bph && hit) exp_data[7:1] = 7'b0000000;
    if (l != r) begin
      bcnt = 0;
      bph  = 1'b0;
    end else if (bcnt == B - 1) begin
      bcnt = 0;
      bph  = ~bph;
    end else begin
      bcnt++;
    end
`endif
    if (r && !l) pos = (pos + N - 1) % N;
    else if (l && !r) pos = (pos + 1) % N;
    #1;
    check_outs(tag);
  endtask

  // reset asserted mid-cycle, optionally with a right pulse that must be lost
  task automatic async_reset(input bit pulse);
    @(posedge clk);
    #3;
    bus.right = pulse;
    rst       = 1'b1;
    #1;
    model_reset();
    check_outs("async_rst");
    @(posedge clk);
    #1;
    check_outs("rst_held");
    @(posedge clk);
    #2;
    rst       = 1'b0;
    bus.right = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.left      = 1'b0;
    bus.right     = 1'b0;
    bus.blink_en  = 1'b0;
    bus.digits_in = 24'h543210;
    #2;
    model_reset();
    check_outs("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // first edge shows digit 0 with dp, then a free-running scan
    for (int i = 0; i < 30; i++) step("scan", 1'b0, 1'b0, 24'h543210, 1'b0);

    async_reset(1'b0);
    step("right", 1'b0, 1'b1, 24'h543210, 1'b0);
    async_reset(1'b0);
    step("left", 1'b1, 1'b0, 24'h543210, 1'b0);
    async_reset(1'b0);
    step("both", 1'b1, 1'b1, 24'h543210, 1'b0);
    async_reset(1'b0);
    for (int i = 0; i < 6; i++) step("right6", 1'b0, 1'b1, 24'h543210, 1'b0);
    step("right6_done", 1'b0, 1'b0, 24'h543210, 1'b0);

    // cursor on digit 2, one full frame
    async_reset(1'b0);
    step("cur2", 1'b1, 1'b0, 24'h987654, 1'b0);
    step("cur2", 1'b1, 1'b0, 24'h987654, 1'b0);
    for (int i = 0; i < 26; i++) step("frame", 1'b0, 1'b0, 24'hFEDCBA, 1'b0);

    // randomized pulses, digits and blink requests
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           24'($urandom), 1'($urandom_range(0, 1)));
    end

`ifdef SEG_BLINK_EN
    async_reset(1'b0);
    for (int i = 0; i < 60; i++) step("blink", 1'b0, 1'b0, 24'h0A0B0C, 1'b1);
    step("blink_move", 1'b0, 1'b1, 24'h0A0B0C, 1'b1);
    for (int i = 0; i < 60; i++) step("blink2", 1'b0, 1'b0, 24'h0A0B0C, 1'b1);
`endif

    // reset mid-slot with a right pulse in flight
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b0, 1'b0, 24'h123456, 1'b0);
    async_reset(1'b1);
    for (int i = 0; i < 10; i++) step("post_rst", 1'b0, 1'b0, 24'h123456, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised N-digit multiplexed 7-segment display driver with an edit cursor.
- Takes packed BCD/hex digit values from the time-keeping logic and scans them onto one shared segment bus with one-hot common selects.
- Moves a one-hot cursor with left/right button pulses and marks it on the decimal point.
- Sits between the clock/counter core and the board display pins; `cursor` feeds the clock core's digit-select input.

Parameters:
- NUM_DIGITS, 6, number of display digits; legal range 2..8.
- SCAN_DIV, 10000, clk cycles per digit slot; legal minimum 2.
- BLINK_DIV, 1500000, clk cycles per blink half-period (used only with SEG_BLINK_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- digits_in  in  4*NUM_DIGITS  packed digit values; [3:0] = digit 0 (least significant, e.g. sec0), [4k+3:4k] = digit k
- left  in  1  one-cycle pulse: move cursor toward digit 1
- right  in  1  one-cycle pulse: move cursor toward digit NUM_DIGITS-1
- blink_en  in  1  blink cursor digit; ignored unless SEG_BLINK_EN
- cursor  out  NUM_DIGITS  one-hot cursor; MSB = digit 0
- seg_com  out  NUM_DIGITS  one-hot common select; MSB = digit 0
- seg_data  out  8  {a,b,c,d,e,f,g,dp}, active-high

Behaviour:
- Reset values (async, all registers):
  - scan counter = 0, scan_idx = 0
  - seg_com = 1<<(NUM_DIGITS-1)
  - cursor = 1<<(NUM_DIGITS-1)
  - seg_data = 8'h00
  - blink counter = 0, blink phase = 0
- Scan counter: width $clog2(SCAN_DIV); counts 0..SCAN_DIV-1 then wraps to 0. tick = (count == SCAN_DIV-1).
- On tick:
  - scan_idx increments, wrapping NUM_DIGITS-1 -> 0.
  - seg_com rotates right: {seg_com[0], seg_com[N-1:1]}.
  - seg_com and scan_idx always agree: bit (N-1-scan_idx) is set.
- seg_data: registered every clk from next_idx (= tick ? wrapped scan_idx+1 : scan_idx).
  - seg_data therefore changes on the same edge as seg_com.
  - seg_data is valid from the first edge after reset release.
  - digits_in is sampled every cycle; no holding is required by the source.
- Decoder, [7:1]: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- dp (seg_data[0]) = 1 iff the digit being shown equals the cursor digit.
- Cursor moves, evaluated per cycle:
  - right only: cursor <= {cursor[N-2:0], cursor[N-1]}
  - left only: cursor <= {cursor[0], cursor[N-1:1]}
  - both or neither: hold
  - Wraps at both ends.
  - A cursor change affects dp on the next seg_data update, i.e. the following clk edge.
- Pulses arriving with rst high are discarded.
- Async rst asserted mid-scan or mid-cursor-move: all outputs take reset values immediately, with no clock needed. Operation resumes from digit 0 on the first edge after release.

Optional Feature:
- Macro: SEG_BLINK_EN
- Defined:
  - A blink counter counts 0..BLINK_DIV-1; at wrap, blink phase toggles.
  - When blink_en=1 and phase=1, the cursor digit's seg_data[7:1] is forced to 0; dp stays 1.
  - Any accepted cursor move clears the blink counter and phase to 0, so the digit is visible at once.
  - blink_en=0 forces the digit visible but does not stop the counter.
- Not defined:
  - No blink counter logic.
  - blink_en is unconnected internally; segments are never blanked.
  - BLINK_DIV is unused.

Test Plan (NUM_DIGITS=6, SCAN_DIV=4, BLINK_DIV=16 unless stated):
1. rst pulse asynchronous to clk -> immediately seg_com=100000, cursor=100000, seg_data=00; first edge after release with digits_in=24'h543210 -> seg_data=11111101 (digit "0", dp=1).
2. digits_in=24'h543210, free-run 30 clks -> seg_com steps every 4 clks: 100000, 010000, 001000, 000100, 000010, 000001, then 100000 at clk 24; seg_data[7:1] = 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, changing on the same edge as seg_com.
3. Cursor moves:
   - right pulse from reset -> cursor=000001.
   - left pulse from reset -> 010000.
   - left and right in the same cycle -> unchanged.
   - 6 consecutive right pulses -> back to 100000.
4. Cursor=001000, scan one full frame -> dp=1 only while seg_com=001000, dp=0 in the other 5 slots.
5. SEG_BLINK_EN defined, blink_en=1, cursor=100000 -> digit-0 segments alternate visible/blank every 16 clks with dp held 1; a right pulse mid-blank -> new cursor digit is visible on the next edge.
6. Async rst asserted mid-slot during a right pulse -> all outputs at reset values, cursor=100000, pulse lost; rst release -> scanning restarts at digit 0 with a full 4-clk slot.
